seg7_scan_driver: RTL

- Parametrised multiplexed driver for a multi-digit common-anode 7-segment display.
- Holds a double-buffered snapshot of per-digit BCD codes and decimal points, and time-multiplexes the digit enables.
- Applies leading-zero blanking and an anti-ghosting guard interval.
- Sits between the frequency-measurement/BCD conversion logic and the board display pins. Replaces the per-digit combinational BCD decoders.

---
 rtl/seg7_scan_driver.sv | 125 ++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver: shadowed BCD digits, per-slot
// guard interval, leading-zero blanking, registered SEG/AN outputs.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*DIGITS-1:0]   D,
  input  logic [DIGITS-1:0]     DP,
  input  logic                  LOAD,
  input  logic                  LZB,
  input  logic                  BLANK,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0]        SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW}};

  // Lit pattern {a,b,c,d,e,f,g} for one BCD code; A is a minus sign.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    s = 7'b0000000;
    case (code)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b0000001;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;
  logic                     wrap;
  logic [DIGITS-1:0][3:0]   sh_code;
  logic [DIGITS-1:0]        sh_dp;
  logic                     lzb_q;
  logic                     blank_q;
  logic [DIGITS-1:0]        lz;
  logic                     zero_run;
  logic [DIGITS-1:0][7:0]   lit;
  logic [7:0]               seg_lit;
  logic [DIGITS-1:0]        an_on;

  assign wrap = (cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap)
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end
  end

  // LZB/BLANK are staged alongside the shadow so all three share the same latency.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh_code <= {DIGITS{4'hF}};
      sh_dp   <= '0;
      lzb_q   <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      if (LOAD) begin
        sh_code <= D;
        sh_dp   <= DP;
      end
      lzb_q   <= LZB;
      blank_q <= BLANK;
    end
  end

  // Walk down from the MSD; a digit blanks while every digit from it upward is 0.
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int j = DIGITS - 1; j > 0; j--) begin
      zero_run = zero_run && (sh_code[j] == 4'h0);
      lz[j]    = lzb_q && zero_run;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign lit[k] = {(lz[k] ? 7'b0000000 : decode(sh_code[k])), sh_dp[k]};
  end

  always_comb begin
    seg_lit = 8'h00;
    an_on   = '0;
    for (int j = 0; j < DIGITS; j++) begin
      if (idx == IW'(j)) begin
        seg_lit  = lit[j];
        an_on[j] = (cnt >= CW'(GUARD)) && !blank_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SEG <= SEG_OFF;
      AN  <= AN_OFF;
    end else begin
      SEG <= SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
      AN  <= AN_ACTIVE_LOW ? ~an_on : an_on;
    end
  end

endmodule
